// File: rtl/accel_mmio_pkg.sv
// Shared register-map constants for the accelerator MMIO front end.
// Holds the register-select codes and the CTRL/STATUS bit positions.
package accel_mmio_pkg;

  localparam logic [1:0] REG_OPERAND = 2'b00;
  localparam logic [1:0] REG_CTRL    = 2'b01;
  localparam logic [1:0] REG_STATUS  = 2'b10;
  localparam logic [1:0] REG_RESULT  = 2'b11;

  localparam int CTRL_GO = 0;
  localparam int CTRL_IE = 1;

  localparam int ST_DONE = 0;
  localparam int ST_ERR  = 1;
  localparam int ST_BUSY = 2;
  localparam int ST_OVR  = 3;

endpackage

// File: rtl/accel_mmio_chan.sv
// One accelerator channel: operand/IE registers, GO pulse, busy tracking,
// sticky DONE/ERR/OVR flags and result capture.
module accel_mmio_chan
  import accel_mmio_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [1:0]        reg_sel,
  input  logic [N_W-1:0]    wd_operand,
  input  logic [1:0]        wd_ctrl,
  input  logic              status_rd,
  input  logic              acc_done,
  input  logic              acc_err,
  input  logic [DATA_W-1:0] acc_result,
  output logic [N_W-1:0]    operand,
  output logic              go,
  output logic              ie,
  output logic [3:0]        status,
  output logic [DATA_W-1:0] result
);

  logic done, err, busy, ovr;

  always_ff @(posedge clk) begin
    if (rst) begin
      operand <= '0;
      go      <= 1'b0;
      ie      <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      ovr     <= 1'b0;
      result  <= '0;
    end else begin
      go <= 1'b0;
      // Read-clear comes first so any set event below on the same edge wins.
      if (status_rd) begin
        done <= 1'b0;
        ovr  <= 1'b0;
      end
      if (wr_en && reg_sel == REG_OPERAND && !busy)
        operand <= wd_operand;
      if (wr_en && reg_sel == REG_CTRL) begin
        ie <= wd_ctrl[CTRL_IE];
        if (wd_ctrl[CTRL_GO]) begin
          if (!busy) begin
            go   <= 1'b1;
            busy <= 1'b1;
            done <= 1'b0;
            err  <= 1'b0;
            ovr  <= 1'b0;
          end else begin
            ovr <= 1'b1;
          end
        end
      end
      // Completion only counts while a job is outstanding.
      if (acc_done && busy) begin
        result <= acc_result;
        err    <= acc_err;
        done   <= 1'b1;
        busy   <= 1'b0;
      end
    end
  end

  always_comb begin
    status          = '0;
    status[ST_DONE] = done;
    status[ST_ERR]  = err;
    status[ST_BUSY] = busy;
    status[ST_OVR]  = ovr;
  end

endmodule

// File: rtl/accel_mmio_ctrl.sv
// MMIO front end for NUM_CH accelerators: address decode, per-channel
// register files, registered read path and level interrupt.
module accel_mmio_ctrl
  import accel_mmio_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int N_W     = 4,
  parameter int NUM_CH  = 2,
  parameter int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int ADDR_W  = CH_BITS + 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        a,
  input  logic                     we,
  input  logic                     re,
  input  logic [DATA_W-1:0]        wd,
  output logic [DATA_W-1:0]        rd,
  output logic                     irq,
  output logic [NUM_CH*N_W-1:0]    acc_n,
  output logic [NUM_CH-1:0]        acc_go,
  input  logic [NUM_CH-1:0]        acc_done,
  input  logic [NUM_CH-1:0]        acc_err,
  input  logic [NUM_CH*DATA_W-1:0] acc_result
);

  logic [1:0]        reg_sel;
  logic [CH_BITS-1:0] ch;
  logic [N_W-1:0]    operand [NUM_CH];
  logic [3:0]        status  [NUM_CH];
  logic [DATA_W-1:0] result  [NUM_CH];
  logic [NUM_CH-1:0] ie;
  logic [NUM_CH-1:0] irq_src;
  logic [DATA_W-1:0] rd_next;
  logic              unused_wd;

  assign reg_sel   = a[1:0];
  assign ch        = a[ADDR_W-1:2];
  assign unused_wd = ^wd;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic hit;
    assign hit = (ch == CH_BITS'(i));

    accel_mmio_chan #(
      .DATA_W(DATA_W),
      .N_W   (N_W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (we && hit),
      .reg_sel   (reg_sel),
      .wd_operand(wd[N_W-1:0]),
      .wd_ctrl   (wd[1:0]),
      .status_rd (re && hit && reg_sel == REG_STATUS),
      .acc_done  (acc_done[i]),
      .acc_err   (acc_err[i]),
      .acc_result(acc_result[i*DATA_W +: DATA_W]),
      .operand   (operand[i]),
      .go        (acc_go[i]),
      .ie        (ie[i]),
      .status    (status[i]),
      .result    (result[i])
    );

    assign acc_n[i*N_W +: N_W] = operand[i];
    assign irq_src[i]          = status[i][ST_DONE] & ie[i];
  end

  // Unmatched channel indices fall through to zero.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch == CH_BITS'(i)) begin
        case (reg_sel)
          REG_OPERAND: rd_next = DATA_W'(operand[i]);
          REG_CTRL:    rd_next[CTRL_IE] = ie[i];
          REG_STATUS:  rd_next = DATA_W'(status[i]);
          default:     rd_next = result[i];
        endcase
      end
    end
  end

  // Read data and interrupt stage
  always_ff @(posedge clk) begin
    if (rst) begin
      rd  <= '0;
      irq <= 1'b0;
    end else begin
      if (re)
        rd <= rd_next;
      irq <= |irq_src;
    end
  end

endmodule

// File: tb/tb_accel_mmio_ctrl.sv
// Directed self-checking bench for accel_mmio_ctrl with three channels,
// so channel index 3 exercises the out-of-range decode.
module tb_accel_mmio_ctrl;

  localparam int DATA_W = 32;
  localparam int N_W    = 4;
  localparam int NUM_CH = 3;
  localparam int ADDR_W = 4;

  logic                     clk;
  logic                     rst;
  logic [ADDR_W-1:0]        a;
  logic                     we;
  logic                     re;
  logic [DATA_W-1:0]        wd;
  logic [DATA_W-1:0]        rd;
  logic                     irq;
  logic [NUM_CH*N_W-1:0]    acc_n;
  logic [NUM_CH-1:0]        acc_go;
  logic [NUM_CH-1:0]        acc_done;
  logic [NUM_CH-1:0]        acc_err;
  logic [NUM_CH*DATA_W-1:0] acc_result;

  int n_tests = 0;
  int n_fail  = 0;
  int go_cnt [NUM_CH];
  int go_snap;
  logic [DATA_W-1:0] v;

  accel_mmio_ctrl #(
    .DATA_W(DATA_W),
    .N_W   (N_W),
    .NUM_CH(NUM_CH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .we        (we),
    .re        (re),
    .wd        (wd),
    .rd        (rd),
    .irq       (irq),
    .acc_n     (acc_n),
    .acc_go    (acc_go),
    .acc_done  (acc_done),
    .acc_err   (acc_err),
    .acc_result(acc_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial for (int i = 0; i < NUM_CH; i++) go_cnt[i] = 0;
  always @(negedge clk)
    for (int i = 0; i < NUM_CH; i++)
      if (acc_go[i]) go_cnt[i] = go_cnt[i] + 1;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] ch, input logic [1:0] rs,
                        input logic [DATA_W-1:0] data);
    a  = {ch, rs};
    wd = data;
    we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] ch, input logic [1:0] rs,
                        output logic [DATA_W-1:0] data);
    a  = {ch, rs};
    re = 1'b1;
    tick();
    re   = 1'b0;
    data = rd;
  endtask

  task automatic pulse_done(input int ch, input logic [DATA_W-1:0] res,
                            input logic err);
    acc_done[ch] = 1'b1;
    acc_err[ch]  = err;
    acc_result[ch*DATA_W +: DATA_W] = res;
    tick();
    acc_done = '0;
    acc_err  = '0;
  endtask

  initial begin
    rst = 1'b1; a = '0; we = 1'b0; re = 1'b0; wd = '0;
    acc_done = '0; acc_err = '0; acc_result = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset_rd", rd, 0);
    check("reset_irq", {31'd0, irq}, 0);
    check("reset_go", {29'd0, acc_go}, 0);
    check("reset_n", {20'd0, acc_n}, 0);

    // Basic factorial on channel 0
    bus_wr(0, 2'b00, 5);
    check("basic_n", {28'd0, acc_n[3:0]}, 5);
    go_snap = go_cnt[0];
    bus_wr(0, 2'b01, 1);
    check("basic_go_hi", {31'd0, acc_go[0]}, 1);
    bus_rd(0, 2'b10, v);
    check("basic_busy", v, 32'h4);
    check("basic_go_lo", {31'd0, acc_go[0]}, 0);
    tick();
    pulse_done(0, 120, 1'b0);
    check("basic_go_once", go_cnt[0] - go_snap, 1);
    tick();
    check("basic_no_irq", {31'd0, irq}, 0);
    bus_rd(0, 2'b10, v);
    check("basic_done", v, 32'h1);
    bus_rd(0, 2'b11, v);
    check("basic_result", v, 120);
    bus_rd(0, 2'b10, v);
    check("basic_cleared", v, 32'h0);

    // Overrun on channel 1
    bus_wr(1, 2'b00, 3);
    go_snap = go_cnt[1];
    bus_wr(1, 2'b01, 1);
    bus_wr(1, 2'b01, 1);
    bus_wr(1, 2'b00, 4);
    bus_rd(1, 2'b00, v);
    check("ovr_operand", v, 3);
    check("ovr_n", {28'd0, acc_n[7:4]}, 3);
    pulse_done(1, 6, 1'b0);
    check("ovr_go_once", go_cnt[1] - go_snap, 1);
    bus_rd(1, 2'b10, v);
    check("ovr_after", v, 32'h9);
    bus_wr(1, 2'b01, 1);
    bus_wr(1, 2'b01, 1);
    bus_rd(1, 2'b10, v);
    check("ovr_busy", v, 32'hC);
    bus_rd(1, 2'b10, v);
    check("ovr_rdclr", v, 32'h4);
    pulse_done(1, 6, 1'b0);
    bus_rd(1, 2'b10, v);
    check("ovr_done2", v, 32'h1);

    // Interrupt on channel 0
    bus_wr(0, 2'b01, 3);
    tick();
    pulse_done(0, 24, 1'b0);
    check("irq_lag", {31'd0, irq}, 0);
    tick();
    check("irq_set", {31'd0, irq}, 1);
    bus_rd(0, 2'b10, v);
    check("irq_status", v, 32'h1);
    check("irq_hold", {31'd0, irq}, 1);
    tick();
    check("irq_clr", {31'd0, irq}, 0);
    bus_rd(0, 2'b01, v);
    check("ctrl_ie", v, 32'h2);

    // Completion with error racing a STATUS read on channel 1
    bus_wr(1, 2'b01, 1);
    tick();
    a = {2'd1, 2'b10};
    re = 1'b1;
    acc_done[1] = 1'b1;
    acc_err[1]  = 1'b1;
    acc_result[DATA_W +: DATA_W] = 7;
    tick();
    re = 1'b0; acc_done = '0; acc_err = '0;
    check("race_pre", rd, 32'h4);
    bus_rd(1, 2'b10, v);
    check("race_post", v, 32'h3);
    bus_rd(1, 2'b10, v);
    check("race_err_sticky", v, 32'h2);
    bus_rd(1, 2'b11, v);
    check("race_result", v, 7);

    // Reset while channel 0 is busy
    bus_wr(0, 2'b01, 3);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_rd", rd, 0);
    check("rstmid_go", {29'd0, acc_go}, 0);
    pulse_done(0, 99, 1'b0);
    tick();
    check("rstmid_irq", {31'd0, irq}, 0);
    bus_rd(0, 2'b10, v);
    check("rstmid_status", v, 0);
    bus_rd(0, 2'b11, v);
    check("rstmid_result", v, 0);
    check("rstmid_n", {20'd0, acc_n}, 0);

    // Simultaneous write/read, then out-of-range channel 3
    bus_wr(2, 2'b00, 9);
    bus_rd(2, 2'b00, v);
    check("wr_base", v, 9);
    a = {2'd2, 2'b00}; wd = 32'hA; we = 1'b1; re = 1'b1;
    tick();
    we = 1'b0; re = 1'b0;
    check("wr_rd_pre", rd, 9);
    bus_rd(2, 2'b00, v);
    check("wr_rd_post", v, 32'hA);
    go_snap = go_cnt[0] + go_cnt[1] + go_cnt[2];
    bus_wr(3, 2'b00, 5);
    bus_wr(3, 2'b01, 1);
    tick();
    check("oor_go", go_cnt[0] + go_cnt[1] + go_cnt[2] - go_snap, 0);
    check("oor_n", {20'd0, acc_n}, 32'hA00);
    bus_rd(3, 2'b00, v);
    check("oor_operand", v, 0);
    bus_rd(2, 2'b00, v);
    bus_rd(3, 2'b11, v);
    check("oor_result", v, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
